// File: rtl/ycbcr2rgb_pipe.sv
// YCbCr 4:4:4 to RGB converter, BT.601/BT.709, limited/full range, frame-deferred mode switch.
// Latency: 5 enabled cycles for data, sync and DE.
// Backpressure: none; i_ce low freezes every register.
module ycbcr2rgb_pipe #(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 8,
    parameter int FRAC_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic [IN_W-1:0]   i_data_y,
    input  logic [IN_W-1:0]   i_data_cb,
    input  logic [IN_W-1:0]   i_data_cr,
    input  logic              i_sync_h,
    input  logic              i_sync_v,
    input  logic              i_de,
    input  logic [1:0]        i_mode,
    output logic [OUT_W-1:0]  o_data_r,
    output logic [OUT_W-1:0]  o_data_g,
    output logic [OUT_W-1:0]  o_data_b,
    output logic              o_sync_h,
    output logic              o_sync_v,
    output logic              o_de,
    output logic [1:0]        o_mode_active,
    output logic              o_mode_pending
);
    localparam int K  = IN_W - 8;
    localparam int S  = FRAC_W + IN_W - OUT_W;
    localparam int CW = FRAC_W + 3;
    localparam int DW = IN_W + 1;
    localparam int PW = DW + CW;
    localparam int SW = PW + 2;

    function automatic logic signed [CW-1:0] coef(input real c);
        return CW'($rtoi(c * (2.0 ** FRAC_W) + 0.5));
    endfunction

    localparam logic signed [DW-1:0] Y_OFS = DW'(16 << K);
    localparam logic signed [DW-1:0] C_OFS = DW'(128 << K);
    localparam logic signed [SW-1:0] RND   = SW'(1) <<< (S - 1);
    localparam logic signed [SW-1:0] MAXV  = SW'((1 << OUT_W) - 1);

    // ---------------- mode FSM ----------------
    typedef enum logic {ST_RUN, ST_PEND} state_t;
    state_t     state;
    logic [1:0] mode_act;
    logic       vs_prev;
    logic       vs_rise;
    logic [1:0] mode_next;

    assign vs_rise   = i_sync_v & ~vs_prev;
    assign mode_next = vs_rise ? i_mode : mode_act;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= ST_RUN;
            mode_act       <= 2'b00;
            vs_prev        <= 1'b0;
            o_mode_pending <= 1'b0;
        end else if (i_ce) begin
            vs_prev  <= i_sync_v;
            mode_act <= mode_next;
            case (state)
                ST_RUN: if (!vs_rise && i_mode != mode_act) begin
                    state          <= ST_PEND;
                    o_mode_pending <= 1'b1;
                end
                ST_PEND: if (vs_rise || i_mode == mode_act) begin
                    state          <= ST_RUN;
                    o_mode_pending <= 1'b0;
                end
                default: begin
                    state          <= ST_RUN;
                    o_mode_pending <= 1'b0;
                end
            endcase
        end
    end

    assign o_mode_active = mode_act;

    // ---------------- datapath ----------------
    logic signed [DW-1:0] s1_y, s1_cb, s1_cr;
    logic [1:0]           s1_mode;
    logic signed [PW-1:0] s2_py, s2_pr, s2_pgb, s2_pgr, s2_pb;
    logic signed [SW-1:0] s3_r, s3_g, s3_b;
    logic signed [SW-1:0] s4_r, s4_g, s4_b;
    logic [4:0][2:0]      tim_pipe;
    logic signed [DW-1:0] y_ofs;
    logic signed [CW-1:0] c_y, c_r, c_gb, c_gr, c_b;

    assign y_ofs = mode_next[1] ? '0 : Y_OFS;

    // Coefficients follow the mode latched with the pixel, not the live FSM.
    always_comb begin
        c_y  = coef(255.0 / 219.0);
        c_r  = coef(1.596);
        c_gb = coef(0.392);
        c_gr = coef(0.813);
        c_b  = coef(2.017);
        case (s1_mode)
            2'b01: begin
                c_r = coef(1.793); c_gb = coef(0.213); c_gr = coef(0.533); c_b = coef(2.112);
            end
            2'b10: begin
                c_y = coef(1.0);
                c_r = coef(1.402); c_gb = coef(0.344); c_gr = coef(0.714); c_b = coef(1.772);
            end
            2'b11: begin
                c_y = coef(1.0);
                c_r = coef(1.5748); c_gb = coef(0.1873); c_gr = coef(0.4681); c_b = coef(1.8556);
            end
            default: ;
        endcase
    end

    function automatic logic [OUT_W-1:0] clamp(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (v > MAXV)
            return '1;
        else
            return v[OUT_W-1:0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_y <= '0; s1_cb <= '0; s1_cr <= '0; s1_mode <= 2'b00;
            s2_py <= '0; s2_pr <= '0; s2_pgb <= '0; s2_pgr <= '0; s2_pb <= '0;
            s3_r <= '0; s3_g <= '0; s3_b <= '0;
            s4_r <= '0; s4_g <= '0; s4_b <= '0;
            o_data_r <= '0; o_data_g <= '0; o_data_b <= '0;
            tim_pipe <= '0;
        end else if (i_ce) begin
            s1_y    <= $signed({1'b0, i_data_y})  - y_ofs;
            s1_cb   <= $signed({1'b0, i_data_cb}) - C_OFS;
            s1_cr   <= $signed({1'b0, i_data_cr}) - C_OFS;
            s1_mode <= mode_next;

            s2_py  <= PW'(s1_y)  * PW'(c_y);
            s2_pr  <= PW'(s1_cr) * PW'(c_r);
            s2_pgb <= PW'(s1_cb) * PW'(c_gb);
            s2_pgr <= PW'(s1_cr) * PW'(c_gr);
            s2_pb  <= PW'(s1_cb) * PW'(c_b);

            s3_r <= SW'(s2_py) + SW'(s2_pr);
            s3_g <= SW'(s2_py) - SW'(s2_pgb) - SW'(s2_pgr);
            s3_b <= SW'(s2_py) + SW'(s2_pb);

            s4_r <= (s3_r + RND) >>> S;
            s4_g <= (s3_g + RND) >>> S;
            s4_b <= (s3_b + RND) >>> S;

            o_data_r <= clamp(s4_r);
            o_data_g <= clamp(s4_g);
            o_data_b <= clamp(s4_b);

            tim_pipe <= {tim_pipe[3:0], {i_sync_h, i_sync_v, i_de}};
        end
    end

    assign o_sync_h = tim_pipe[4][2];
    assign o_sync_v = tim_pipe[4][1];
    assign o_de     = tim_pipe[4][0];

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Directed bench for ycbcr2rgb_pipe at IN_W=10, OUT_W=8, FRAC_W=12; expected values hand-computed.
module tb_ycbcr2rgb_pipe;
    logic       i_clk = 1'b0;
    logic       i_rst, i_ce;
    logic [9:0] i_data_y, i_data_cb, i_data_cr;
    logic       i_sync_h, i_sync_v, i_de;
    logic [1:0] i_mode;
    logic [7:0] o_data_r, o_data_g, o_data_b;
    logic       o_sync_h, o_sync_v, o_de;
    logic [1:0] o_mode_active;
    logic       o_mode_pending;

    int total = 0;
    int bad   = 0;
    int p, n_en, idx;
    logic ce_now;

    always #5 i_clk = ~i_clk;

    ycbcr2rgb_pipe #(.IN_W(10), .OUT_W(8), .FRAC_W(12)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
        .i_data_y(i_data_y), .i_data_cb(i_data_cb), .i_data_cr(i_data_cr),
        .i_sync_h(i_sync_h), .i_sync_v(i_sync_v), .i_de(i_de),
        .i_mode(i_mode),
        .o_data_r(o_data_r), .o_data_g(o_data_g), .o_data_b(o_data_b),
        .o_sync_h(o_sync_h), .o_sync_v(o_sync_v), .o_de(o_de),
        .o_mode_active(o_mode_active), .o_mode_pending(o_mode_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_data_y = 10'd64; i_data_cb = 10'd512; i_data_cr = 10'd512;
        i_de = 1'b0; i_sync_h = 1'b0; i_sync_v = 1'b0;
    endtask

    // One DE pixel, then idle; output must appear on the 5th edge and not the 4th.
    task automatic px(input logic [9:0] y, input logic [9:0] cb, input logic [9:0] cr,
                      input logic vs, input logic [7:0] er, input logic [7:0] eg,
                      input logic [7:0] eb, input string tag);
        i_data_y = y; i_data_cb = cb; i_data_cr = cr; i_de = 1'b1; i_sync_v = vs;
        @(posedge i_clk); #1;
        idle();
        repeat (3) @(posedge i_clk);
        #1;
        chk({tag, "_de_early"}, 32'(o_de), 32'd0);
        @(posedge i_clk); #1;
        chk({tag, "_de"}, 32'(o_de), 32'd1);
        chk({tag, "_vs"}, 32'(o_sync_v), 32'(vs));
        chk({tag, "_r"}, 32'(o_data_r), 32'(er));
        chk({tag, "_g"}, 32'(o_data_g), 32'(eg));
        chk({tag, "_b"}, 32'(o_data_b), 32'(eb));
    endtask

    initial begin
        i_rst = 1'b0; i_ce = 1'b1; i_mode = 2'b11;
        i_data_y = 10'd900; i_data_cb = 10'd700; i_data_cr = 10'd300;
        i_de = 1'b1; i_sync_h = 1'b1; i_sync_v = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_r", 32'(o_data_r), 32'd0);
        chk("rst_g", 32'(o_data_g), 32'd0);
        chk("rst_b", 32'(o_data_b), 32'd0);
        chk("rst_de", 32'(o_de), 32'd0);
        chk("rst_hs", 32'(o_sync_h), 32'd0);
        chk("rst_vs", 32'(o_sync_v), 32'd0);
        chk("rst_mode", 32'(o_mode_active), 32'd0);
        chk("rst_pend", 32'(o_mode_pending), 32'd0);

        i_mode = 2'b00; idle();
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;

        // BT.601 limited range
        px(10'd64,   10'd512,  10'd512,  1'b0, 8'd0,   8'd0,   8'd0,   "black");
        px(10'd940,  10'd512,  10'd512,  1'b0, 8'd255, 8'd255, 8'd255, "white");
        px(10'd1023, 10'd512,  10'd1023, 1'b0, 8'd255, 8'd175, 8'd255, "clamp_hi");
        px(10'd0,    10'd512,  10'd512,  1'b0, 8'd0,   8'd0,   8'd0,   "clamp_lo");
        px(10'd64,   10'd1023, 10'd1023, 1'b0, 8'd204, 8'd0,   8'd255, "clamp_mix");

        // Deferred switch to BT.709
        i_mode = 2'b01;
        @(posedge i_clk); #1;
        chk("pend_set", 32'(o_mode_pending), 32'd1);
        chk("pend_act", 32'(o_mode_active), 32'd0);
        px(10'd512, 10'd600, 10'd512, 1'b0, 8'd130, 8'd122, 8'd175, "pre709");
        chk("pend_hold", 32'(o_mode_pending), 32'd1);
        px(10'd512, 10'd600, 10'd512, 1'b1, 8'd130, 8'd126, 8'd177, "edge709");
        chk("act709", 32'(o_mode_active), 32'd1);
        chk("pend_clr", 32'(o_mode_pending), 32'd0);
        px(10'd512, 10'd600, 10'd512, 1'b0, 8'd130, 8'd126, 8'd177, "post709");

        // Mode change coincident with vsync edge: applies to that pixel
        i_mode = 2'b10;
        px(10'd512, 10'd512, 10'd512, 1'b1, 8'd128, 8'd128, 8'd128, "full601");
        chk("act_full", 32'(o_mode_active), 32'd2);
        chk("pend_full", 32'(o_mode_pending), 32'd0);

        // Request withdrawn before any edge
        i_mode = 2'b11;
        @(posedge i_clk); #1;
        chk("wd_pend", 32'(o_mode_pending), 32'd1);
        i_mode = 2'b10;
        @(posedge i_clk); #1;
        chk("wd_clr", 32'(o_mode_pending), 32'd0);
        chk("wd_act", 32'(o_mode_active), 32'd2);

        // Ramp with a 3-cycle stall; full range so Y=4*(10+k) maps to 10+k
        p = 0; n_en = 0;
        for (int j = 0; j < 16; j++) begin
            ce_now = !(j >= 7 && j <= 9);
            i_ce = ce_now;
            if (ce_now) begin
                i_data_y = 10'(4 * (10 + p)); i_data_cb = 10'd512; i_data_cr = 10'd512;
                i_de = p[0]; i_sync_h = p[1]; i_sync_v = 1'b0;
            end else begin
                i_data_y = 10'd1000; i_data_cb = 10'd100; i_data_cr = 10'd900;
                i_de = 1'b1; i_sync_h = 1'b1; i_sync_v = 1'b0;
            end
            @(posedge i_clk); #1;
            if (ce_now) begin
                p++;
                n_en++;
            end
            if (n_en >= 5) begin
                idx = n_en - 5;
                chk($sformatf("ramp%0d_r", j), 32'(o_data_r), 32'(10 + idx));
                chk($sformatf("ramp%0d_b", j), 32'(o_data_b), 32'(10 + idx));
                chk($sformatf("ramp%0d_de", j), 32'(o_de), 32'(idx[0]));
                chk($sformatf("ramp%0d_hs", j), 32'(o_sync_h), 32'(idx[1]));
            end
        end
        i_ce = 1'b1; idle();

        // Mid-frame reset pulse
        i_data_y = 10'd940; i_de = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;
        chk("pre_rst_r", 32'(o_data_r), 32'd235);
        chk("pre_rst_de", 32'(o_de), 32'd1);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_r", 32'(o_data_r), 32'd0);
        chk("mid_rst_de", 32'(o_de), 32'd0);
        chk("mid_rst_mode", 32'(o_mode_active), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge i_clk); #1;
            if (e < 5) begin
                chk($sformatf("flush%0d_de", e), 32'(o_de), 32'd0);
                chk($sformatf("flush%0d_r", e), 32'(o_data_r), 32'd0);
            end else begin
                chk("first_de", 32'(o_de), 32'd1);
                chk("first_r", 32'(o_data_r), 32'd255);
                chk("first_mode", 32'(o_mode_active), 32'd0);
                chk("first_pend", 32'(o_mode_pending), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
